// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Fetch-side bus between the core control logic and the PC sequencer.
//   master : control logic (drives redirect requests, observes PC/RAS state)
//   slave  : pc_sequencer
//   Signals
//     pc_write      stall control, 0 holds the PC (exceptions still taken)
//     exc_req       exception redirect request
//     branch_taken  / branch_target  taken-branch redirect
//     jump / jump_target / call       jump redirect, call pushes pc+STEP
//     ret / ret_target                return, ret_target used if RAS empty
//     pc, pc_plus_step, epc           current PC, PC+STEP, exception PC
//     ras_empty, ras_full             return-address stack occupancy
//     ras_miss, misalign              single-cycle status pulses
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             pc_write;
  logic             exc_req;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] ret_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] epc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_miss;
  logic             misalign;

  modport master (
    output pc_write, exc_req, branch_taken, branch_target, jump, jump_target,
           call, ret, ret_target,
    input  pc, pc_plus_step, epc, ras_empty, ras_full, ras_miss, misalign
  );

  modport slave (
    input  pc_write, exc_req, branch_taken, branch_target, jump, jump_target,
           call, ret, ret_target,
    output pc, pc_plus_step, epc, ras_empty, ras_full, ras_miss, misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program counter for the fetch stage with stall, prioritised redirects
//   (exception > stall > return > jump > branch > sequential), exception PC
//   capture and a circular return-address stack (RAS) for call/return.
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : pc_sequencer_if.slave (redirect inputs, PC/RAS outputs)
//   Optional feature
//     PC_ALIGN_CHECK_EN : when defined, a misaligned next PC (low log2(STEP)
//     bits set) traps to EXC_VECTOR with epc = offending target and a
//     one-cycle misalign pulse. When undefined, misalign is tied to 0.
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int               RAS_DEPTH    = 4
) (
  input logic             clk,
  input logic             rst,
  pc_sequencer_if.slave   bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0] ptr_q, top_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             push, pop;
  logic             ras_miss_q, ras_miss_d;
  logic             ras_empty;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  logic             misalign_q, misalign_d;
`endif

  // ptr_q is the next free slot; the most recent entry sits just below it.
  // With RAS_DEPTH a power of two the pointer wraps naturally, so a push
  // when full lands on the oldest entry.
  assign top_ptr   = ptr_q - 1'b1;
  assign pc_inc    = pc_q + WIDTH'(STEP);
  assign ras_empty = (cnt_q == '0);

  always_comb begin
    pc_d       = pc_inc;
    epc_d      = epc_q;
    push       = 1'b0;
    pop        = 1'b0;
    ras_miss_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    if (bus.exc_req) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (!bus.pc_write) begin
      pc_d = pc_q;
    end else begin
      if (bus.ret) begin
        if (ras_empty) begin
          pc_d       = bus.ret_target;
          ras_miss_d = 1'b1;
        end else begin
          pc_d = ras_q[top_ptr];
          pop  = 1'b1;
        end
      end else if (bus.jump) begin
        pc_d = bus.jump_target;
        push = bus.call;
      end else if (bus.branch_taken) begin
        pc_d = bus.branch_target;
      end
`ifdef PC_ALIGN_CHECK_EN
      // Misaligned selection traps instead of loading; the stack is left as is.
      if ((pc_d & ALIGN_MASK) != '0) begin
        epc_d      = pc_d;
        pc_d       = EXC_VECTOR;
        misalign_d = 1'b1;
        push       = 1'b0;
        pop        = 1'b0;
      end
`endif
    end
  end

  // Stage boundary: architectural PC state and RAS bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ras_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      ras_miss_q <= ras_miss_d;
      if (push) begin
        ptr_q <= ptr_q + 1'b1;
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
        ptr_q <= top_ptr;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Stack storage needs no reset: cnt_q gates every read.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_inc;
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign bus.misalign = misalign_q;
`else
  assign bus.misalign = 1'b0;
`endif

  assign bus.pc           = pc_q;
  assign bus.pc_plus_step = pc_inc;
  assign bus.epc          = epc_q;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = (cnt_q == CNT_FULL);
  assign bus.ras_miss     = ras_miss_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer (default parameters). Inputs change #1
//   after a rising edge and outputs are sampled #1 after the following edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exc_req      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.call         = 1'b0;
    bus.ret          = 1'b0;
    bus.pc_write     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.branch_target = '0;
    bus.jump_target   = '0;
    bus.ret_target    = '0;
    rst = 1'b1;
    #1;

    // Test 1: reset, then sequential advance
    step(); step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_empty", bus.ras_empty, 1);
    chk("rst_full", bus.ras_full, 0);
    chk("rst_miss", bus.ras_miss, 0);
    chk("rst_misalign", bus.misalign, 0);
    rst = 1'b0;
    step(); chk("seq_4", bus.pc, 32'h4);
    step(); chk("seq_8", bus.pc, 32'h8);
    step(); chk("seq_c", bus.pc, 32'hC);
    step(); chk("seq_10", bus.pc, 32'h10);

    // Test 2: stall holds despite a taken branch
    bus.pc_write = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
    step(); chk("stall_hold", bus.pc, 32'h10);
    bus.pc_write = 1'b1;
    step(); chk("branch_200", bus.pc, 32'h200);
    idle_inputs();

    // Test 3: call then return
    bus.jump = 1'b1; bus.jump_target = 32'h40;
    step(); chk("jump_40", bus.pc, 32'h40);
    chk("pcps_44", bus.pc_plus_step, 32'h44);
    bus.call = 1'b1; bus.jump_target = 32'h400;
    step(); chk("call_400", bus.pc, 32'h400);
    chk("call_nonempty", bus.ras_empty, 0);
    idle_inputs();
    step(); chk("seq_404", bus.pc, 32'h404);
    bus.ret = 1'b1; bus.ret_target = 32'h1234;
    step(); chk("ret_44", bus.pc, 32'h44);
    chk("ret_empty", bus.ras_empty, 1);

    // Test 4: miss, then overflow the stack
    step(); chk("miss_pc", bus.pc, 32'h1234);
    chk("miss_pulse", bus.ras_miss, 1);
    bus.ret = 1'b0;
    step(); chk("miss_clear", bus.ras_miss, 0);
    chk("seq_1238", bus.pc, 32'h1238);
    bus.jump = 1'b1; bus.call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.jump_target = 32'(i) << 12;
      step();
    end
    chk("five_calls_pc", bus.pc, 32'h5000);
    chk("ras_full", bus.ras_full, 1);
    idle_inputs();
    bus.ret = 1'b1;
    step(); chk("pop1", bus.pc, 32'h4004);
    chk("pop1_notfull", bus.ras_full, 0);
    step(); chk("pop2", bus.pc, 32'h3004);
    step(); chk("pop3", bus.pc, 32'h2004);
    step(); chk("pop4", bus.pc, 32'h1004);
    chk("pop4_empty", bus.ras_empty, 1);
    step(); chk("pop5_target", bus.pc, 32'h1234);
    chk("pop5_miss", bus.ras_miss, 1);
    idle_inputs();

    // Test 5: exception during stall beats a call
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = 32'h30;
    step(); chk("call_30", bus.pc, 32'h30);
    bus.pc_write = 1'b0; bus.exc_req = 1'b1; bus.jump_target = 32'h500;
    step(); chk("exc_pc", bus.pc, 32'h80);
    chk("exc_epc", bus.epc, 32'h30);
    chk("exc_ras_one", bus.ras_empty, 0);
    idle_inputs();
    bus.pc_write = 1'b0; bus.ret = 1'b1;
    step(); chk("stall_ret_hold", bus.pc, 32'h80);
    chk("stall_ret_nopop", bus.ras_empty, 0);
    bus.pc_write = 1'b1;
    step(); chk("exc_ret_pc", bus.pc, 32'h1238);
    chk("exc_ret_empty", bus.ras_empty, 1);
    idle_inputs();

    // Wrap at the top of the address space
    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    step(); chk("pcps_wrap", bus.pc_plus_step, 32'h0);
    idle_inputs();
    step(); chk("pc_wrap", bus.pc, 32'h0);

    // Test 6: misaligned branch target
    bus.branch_taken = 1'b1; bus.branch_target = 32'h102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", bus.pc, 32'h80);
    chk("mis_epc", bus.epc, 32'h102);
    chk("mis_pulse", bus.misalign, 1);
    idle_inputs();
    step(); chk("mis_clear", bus.misalign, 0);
    chk("mis_seq", bus.pc, 32'h84);
`else
    chk("noalign_pc", bus.pc, 32'h102);
    chk("noalign_flag", bus.misalign, 0);
    idle_inputs();
    step(); chk("noalign_seq", bus.pc, 32'h106);
`endif

    // Mid-operation reset drops the stack and a pending jump
    bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = 32'h600;
    step(); chk("pre_rst_call", bus.ras_empty, 0);
    rst = 1'b1;
    step(); chk("mid_rst_pc", bus.pc, 32'h0);
    chk("mid_rst_empty", bus.ras_empty, 1);
    chk("mid_rst_epc", bus.epc, 32'h0);
    rst = 1'b0; idle_inputs();
    step(); chk("post_rst_seq", bus.pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
